instr_prefetch: RTL and testbench

Instruction prefetch unit that sits between the CPU core's fetch stage and the SoC instruction memory interface (`INSTR_REQ/INSTR_VALID/INSTR_ADDR/INSTR_RDATA`). It issues sequential word fetches autonomously and buffers the results in a small first-word-fall-through FIFO. It delivers instructions to the core through a valid/ready handshake. A redirect input (branch/jump/trap) flushes buffered and in-flight fetches and restarts fetching at a new PC.

---
 rtl/instr_prefetch_if.sv | 24 ++
 rtl/instr_prefetch.sv | 211 +++++++++++++++++++++
 tb/tb_instr_prefetch.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_if.sv
// Bundled memory-side and core-side signals of the instruction prefetch unit.
// The master modport is the prefetch unit; the slave modport is its environment.
interface instr_prefetch_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output instr_req, instr_addr, out_valid, out_instr, out_pc,
    input  instr_valid, instr_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  instr_req, instr_addr, out_valid, out_instr, out_pc,
    output instr_valid, instr_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher with a first-word-fall-through FIFO and redirect flush.
// Optional performance counters are enabled with the INSTR_PREFETCH_PERF_EN macro.
module instr_prefetch_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          resn,
  input logic          push_i,
  input logic [CW-1:0] count_i,
  input logic [1:0]    fetch_addr_lo_i
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!resn)
    !(push_i && (count_i == DEPTH_C)));

  a_fetch_addr_aligned: assert property (@(posedge clk) disable iff (!resn)
    fetch_addr_lo_i == 2'b00);
endmodule

module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resn,
  instr_prefetch_if.master  bus
`ifdef INSTR_PREFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetches,
  output logic [31:0]       perf_discards
`endif
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_pc_q    [DEPTH];

  logic          push_s;
  logic          drop_s;
  logic          pop_s;
  logic          out_valid_s;
  logic [CW-1:0] count_after_push_s;
  logic [31:0]   redirect_pc_s;

  assign redirect_pc_s      = bus.redirect_pc & 32'hFFFF_FFFC;
  assign out_valid_s        = (count_q != {CW{1'b0}});
  assign pop_s              = out_valid_s & bus.out_ready;
  assign count_after_push_s = count_q + CW'(1) - CW'(pop_s);

  assign bus.instr_req  = (state_q != ST_IDLE);
  assign bus.instr_addr = fetch_addr_q;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_instr  = fifo_instr_q[rd_ptr_q];
  assign bus.out_pc     = fifo_pc_q[rd_ptr_q];

  // Fetch FSM: request issue, response acceptance and redirect handling.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    push_s       = 1'b0;
    drop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.redirect) begin
          fetch_addr_d = redirect_pc_s;
        end else if (count_q < DEPTH_C) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.instr_valid) begin
          if (bus.redirect) begin
            drop_s       = 1'b1;
            fetch_addr_d = redirect_pc_s;
            state_d      = ST_REQ;
          end else begin
            push_s       = 1'b1;
            fetch_addr_d = fetch_addr_q + 32'd4;
            state_d      = (count_after_push_s < DEPTH_C) ? ST_REQ : ST_IDLE;
          end
        end else if (bus.redirect) begin
          fetch_addr_d = redirect_pc_s;
          state_d      = ST_DISCARD;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DISCARD: begin
        if (bus.redirect) begin
          fetch_addr_d = redirect_pc_s;
        end else begin
          fetch_addr_d = fetch_addr_q;
        end
        // The stale response is consumed here; fetch_addr already points at the target.
        if (bus.instr_valid) begin
          drop_s  = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        fetch_addr_d = fetch_addr_q;
      end
    endcase
  end

  // FIFO pointer and occupancy update; a redirect clears everything after any same-cycle pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= RESET_PC;
      count_q      <= {CW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // FIFO storage; entries reset to zero so the head reads zero out of reset.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]    <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_instr_q[wr_ptr_q] <= bus.instr_rdata;
      fifo_pc_q[wr_ptr_q]    <= fetch_addr_q;
    end
  end

`ifdef INSTR_PREFETCH_PERF_EN
  logic [31:0]   perf_fetches_q;
  logic [31:0]   perf_discards_q;
  logic [CW-1:0] flushed_s;

  assign flushed_s     = bus.redirect ? (count_q - CW'(pop_s)) : {CW{1'b0}};
  assign perf_fetches  = perf_fetches_q;
  assign perf_discards = perf_discards_q;

  // Accepted fetches, plus dropped responses and entries lost to a flush.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      perf_fetches_q  <= 32'h0000_0000;
      perf_discards_q <= 32'h0000_0000;
    end else begin
      perf_fetches_q  <= perf_fetches_q + 32'(push_s);
      perf_discards_q <= perf_discards_q + 32'(drop_s) + 32'(flushed_s);
    end
  end
`endif

  instr_prefetch_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk             (clk),
    .resn            (resn),
    .push_i          (push_s),
    .count_i         (count_q),
    .fetch_addr_lo_i (fetch_addr_q[1:0])
  );
endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch (DEPTH=4, RESET_PC=0x100) with a one-cycle memory responder.
// Counter checks are included when INSTR_PREFETCH_PERF_EN is defined.
module tb_instr_prefetch;
  logic        clk = 1'b0;
  logic        resn;
  logic        mem_en = 1'b0;
  int          n_ans = 0;
  int          ans_base;
  logic [31:0] last_ans = 32'h0;
  int          n_assert = 0;
  int          n_fail = 0;

  instr_prefetch_if bus ();

`ifdef INSTR_PREFETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_discards;
`endif

  instr_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .resn          (resn),
    .bus           (bus)
`ifdef INSTR_PREFETCH_PERF_EN
    ,
    .perf_fetches  (perf_fetches),
    .perf_discards (perf_discards)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: answers every request one cycle after it is seen, while enabled.
  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_en || !bus.instr_req) begin
        bus.instr_valid = 1'b0;
      end else begin
        bus.instr_valid = 1'b1;
        bus.instr_rdata = mdata(bus.instr_addr);
        last_ans        = bus.instr_addr;
        n_ans++;
      end
    end
  end

  initial begin
    resn            = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.instr_req), 32'd0);
    chk("rst_addr", bus.instr_addr, 32'h0000_0100);
    chk("rst_oval", 32'(bus.out_valid), 32'd0);
    chk("rst_oinstr", bus.out_instr, 32'h0);
    chk("rst_opc", bus.out_pc, 32'h0);

    // Reset fetch stream with the core popping every cycle
    resn = 1'b1; bus.out_ready = 1'b1; mem_en = 1'b1;
    @(negedge clk);
    chk("first_req", 32'(bus.instr_req), 32'd1);
    chk("first_addr", bus.instr_addr, 32'h0000_0100);
    chk("first_oval_lo", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_oval", 32'(bus.out_valid), 32'd1);
      chk("stream_pc", bus.out_pc, 32'h100 + 32'(4 * i));
      chk("stream_instr", bus.out_instr, mdata(32'h100 + 32'(4 * i)));
    end
    mem_en = 1'b0;
    @(negedge clk);
    chk("stream_pc_last", bus.out_pc, 32'h0000_0110);
    @(negedge clk);
    chk("stall_oval", 32'(bus.out_valid), 32'd0);
    chk("stall_req", 32'(bus.instr_req), 32'd1);
    chk("stall_addr", bus.instr_addr, 32'h0000_0114);

    // Backpressure: the FIFO fills with exactly four words, then requests stop
    bus.out_ready = 1'b0; ans_base = n_ans; mem_en = 1'b1;
    repeat (8) @(negedge clk);
    chk("bp_req_off", 32'(bus.instr_req), 32'd0);
    chk("bp_fetches", 32'(n_ans - ans_base), 32'd4);
    chk("bp_head", bus.out_pc, 32'h0000_0114);
    chk("bp_next_addr", bus.instr_addr, 32'h0000_0124);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_pop_head", bus.out_pc, 32'h0000_0118);
    repeat (4) @(negedge clk);
    chk("bp_refill_req", 32'(bus.instr_req), 32'd0);
    chk("bp_refill_cnt", 32'(n_ans - ans_base), 32'd5);
    chk("bp_refill_addr", last_ans, 32'h0000_0124);
    chk("bp_after_addr", bus.instr_addr, 32'h0000_0128);
    mem_en = 1'b0; bus.out_ready = 1'b1;
    chk("drain_pc0", bus.out_pc, 32'h0000_0118);
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      chk("drain_pc", bus.out_pc, 32'h118 + 32'(4 * j));
    end
    @(negedge clk);
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    chk("drain_req", 32'(bus.instr_req), 32'd1);
    chk("drain_addr", bus.instr_addr, 32'h0000_0128);

    // Redirect while a request is outstanding, with one buffered entry flushed
    bus.out_ready = 1'b0; mem_en = 1'b1;
    @(negedge clk);
    mem_en = 1'b0;
    @(negedge clk);
    chk("rd_buf_pc", bus.out_pc, 32'h0000_0128);
    chk("rd_wait_addr", bus.instr_addr, 32'h0000_012C);
    @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_2002;
    @(negedge clk);
    bus.redirect = 1'b0; mem_en = 1'b1;
    chk("rd_flush_oval", 32'(bus.out_valid), 32'd0);
    chk("rd_disc_req", 32'(bus.instr_req), 32'd1);
    @(negedge clk);
    chk("rd_disc_oval", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("rd_target_addr", bus.instr_addr, 32'h0000_2000);
    chk("rd_stale_hidden", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("rd_new_oval", 32'(bus.out_valid), 32'd1);
    chk("rd_new_pc", bus.out_pc, 32'h0000_2000);
    chk("rd_new_instr", bus.out_instr, mdata(32'h0000_2000));
`ifdef INSTR_PREFETCH_PERF_EN
    chk("perf_fetch_a", perf_fetches, 32'd12);
    chk("perf_disc_a", perf_discards, 32'd2);
`endif

    // Redirect coincident with a response and with a pop of the head entry
    bus.out_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_3000;
    @(negedge clk);
    bus.redirect = 1'b0;
    chk("co_no_redeliver", 32'(bus.out_valid), 32'd0);
    chk("co_req", 32'(bus.instr_req), 32'd1);
    chk("co_addr", bus.instr_addr, 32'h0000_3000);
    @(negedge clk);
    chk("co_new_pc", bus.out_pc, 32'h0000_3000);
    chk("co_new_instr", bus.out_instr, mdata(32'h0000_3000));
`ifdef INSTR_PREFETCH_PERF_EN
    chk("perf_fetch_b", perf_fetches, 32'd13);
    chk("perf_disc_b", perf_discards, 32'd3);
`endif
    mem_en = 1'b0;
    @(negedge clk);
    chk("co_next_pc", bus.out_pc, 32'h0000_3004);
    @(negedge clk);
    chk("co_empty", 32'(bus.out_valid), 32'd0);
    chk("co_wait_addr", bus.instr_addr, 32'h0000_3008);

    // Address wrap; low redirect bits are ignored
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    bus.redirect = 1'b0; mem_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("wrap_addr0", bus.instr_addr, 32'hFFFF_FFFC);
    chk("wrap_oval0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    mem_en = 1'b0;
    chk("wrap_pc0", bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_addr1", bus.instr_addr, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_pc1", bus.out_pc, 32'h0000_0000);
    chk("wrap_instr1", bus.out_instr, mdata(32'h0000_0000));
`ifdef INSTR_PREFETCH_PERF_EN
    chk("perf_fetch_c", perf_fetches, 32'd16);
    chk("perf_disc_c", perf_discards, 32'd4);
`endif

    // Asynchronous reset in the middle of an outstanding request
    @(negedge clk);
    chk("ar_req_before", 32'(bus.instr_req), 32'd1);
    chk("ar_addr_before", bus.instr_addr, 32'h0000_0004);
    #2 resn = 1'b0;
    #1;
    chk("ar_req_drop", 32'(bus.instr_req), 32'd0);
    chk("ar_addr_reset", bus.instr_addr, 32'h0000_0100);
    chk("ar_oval", 32'(bus.out_valid), 32'd0);
`ifdef INSTR_PREFETCH_PERF_EN
    chk("ar_perf_fetch", perf_fetches, 32'd0);
    chk("ar_perf_disc", perf_discards, 32'd0);
`endif
    @(negedge clk);
    resn = 1'b1; mem_en = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ar_restart_req", 32'(bus.instr_req), 32'd1);
    chk("ar_restart_addr", bus.instr_addr, 32'h0000_0100);
    @(negedge clk);
    chk("ar_restart_oval", 32'(bus.out_valid), 32'd1);
    chk("ar_restart_pc", bus.out_pc, 32'h0000_0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
